// File: rtl/game_flow_controller.sv
// -----------------------------------------------------------------------------
// game_flow_controller
//   Sequencing FSM for the 2048 board datapath. Converts direction-button
//   levels into single one-hot move commands, handshakes each move with the
//   board, spawns a new tile into an empty cell and evaluates win/lose.
//
// Ports
//   clk, rst            clock, asynchronous active-high reset
//   btn_up/down/left/right  synchronised button levels
//   new_game            level; restarts the game from any state
//   win_sel[3:0]        {d,c,b,a} target select: a=exp 11 ... d=exp 8
//   cell_matrix         16 tile exponents, idx = row*4+col, 0 = empty
//   board_done          1-cycle pulse, move pass finished
//   board_moved         valid with board_done, something moved/merged
//   move_cmd[3:0]       one-hot {right,left,down,up}, held until board_done
//   clear_board         1-cycle pulse, board zeroes all cells
//   spawn_en            1-cycle pulse, write spawn_val into spawn_idx
//   spawn_idx/spawn_val target cell / exponent (1 = tile 2, 2 = tile 4)
//   win, lose           sticky game-over flags
//   busy                low only in READY, WIN, LOSE
//   timeout_err         sticky, set on MOVE timeout, cleared by new_game
// -----------------------------------------------------------------------------
module game_flow_controller #(
    parameter logic [15:0] LFSR_SEED   = 16'hACE1,
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             btn_up,
    input  logic             btn_down,
    input  logic             btn_left,
    input  logic             btn_right,
    input  logic             new_game,
    input  logic [3:0]       win_sel,
    input  logic [15:0][3:0] cell_matrix,
    input  logic             board_done,
    input  logic             board_moved,
    output logic [3:0]       move_cmd,
    output logic             clear_board,
    output logic             spawn_en,
    output logic [3:0]       spawn_idx,
    output logic [3:0]       spawn_val,
    output logic             win,
    output logic             lose,
    output logic             busy,
    output logic             timeout_err
);

    localparam logic [3:0] S_IDLE     = 4'd0;
    localparam logic [3:0] S_CLEAR    = 4'd1;
    localparam logic [3:0] S_SPAWN    = 4'd2;
    localparam logic [3:0] S_SPAWN_WR = 4'd3;
    localparam logic [3:0] S_READY    = 4'd4;
    localparam logic [3:0] S_MOVE     = 4'd5;
    localparam logic [3:0] S_CHECK    = 4'd6;
    localparam logic [3:0] S_WIN      = 4'd7;
    localparam logic [3:0] S_LOSE     = 4'd8;

    localparam int TMR_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYC - 1);

    logic [3:0]       state_q, state_d;
    logic [3:0]       btn_q, btn_d;
    logic [15:0]      lfsr_q, lfsr_d;
    logic [3:0]       move_cmd_q, move_cmd_d;
    logic             clear_board_q, clear_board_d;
    logic             spawn_en_q, spawn_en_d;
    logic [3:0]       spawn_idx_q, spawn_idx_d;
    logic [3:0]       spawn_val_q, spawn_val_d;
    logic             win_q, win_d;
    logic             lose_q, lose_d;
    logic             busy_q, busy_d;
    logic             timeout_err_q, timeout_err_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic [3:0]       scan_idx_q, scan_idx_d;
    logic [3:0]       scan_cnt_q, scan_cnt_d;
    logic [1:0]       spawn_left_q, spawn_left_d;
    logic             opening_q, opening_d;

    logic [3:0] btn_vec, btn_edge;
    logic [3:0] win_target;
    logic       any_zero, any_pair, any_win;

    // Board evaluation used by CHECK. Lowest set win_sel bit picks the target.
    always_comb begin
        if (win_sel[0])      win_target = 4'd11;
        else if (win_sel[1]) win_target = 4'd10;
        else if (win_sel[2]) win_target = 4'd9;
        else if (win_sel[3]) win_target = 4'd8;
        else                 win_target = 4'd11;

        any_zero = 1'b0;
        any_win  = 1'b0;
        any_pair = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (cell_matrix[i] == 4'd0)        any_zero = 1'b1;
            if (cell_matrix[i] >= win_target)  any_win  = 1'b1;
        end
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 3; c++) begin
                if (cell_matrix[r*4+c] != 4'd0 && cell_matrix[r*4+c] == cell_matrix[r*4+c+1])
                    any_pair = 1'b1;
            end
        end
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (cell_matrix[r*4+c] != 4'd0 && cell_matrix[r*4+c] == cell_matrix[r*4+c+4])
                    any_pair = 1'b1;
            end
        end
    end

    always_comb begin
        btn_vec  = {btn_right, btn_left, btn_down, btn_up};
        btn_edge = btn_vec & ~btn_q;
        btn_d    = btn_vec;
        lfsr_d   = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

        // NOTE: every variable gets a default here so no path leaves one
        // unassigned; otherwise synthesis infers a latch.
        state_d       = state_q;
        move_cmd_d    = move_cmd_q;
        clear_board_d = 1'b0;
        spawn_en_d    = 1'b0;
        spawn_idx_d   = spawn_idx_q;
        spawn_val_d   = spawn_val_q;
        win_d         = win_q;
        lose_d        = lose_q;
        timeout_err_d = timeout_err_q;
        timer_d       = timer_q;
        scan_idx_d    = scan_idx_q;
        scan_cnt_d    = scan_cnt_q;
        spawn_left_d  = spawn_left_q;
        opening_d     = opening_q;

        if (new_game) begin
            state_d       = S_CLEAR;
            clear_board_d = 1'b1;
            move_cmd_d    = 4'd0;
            win_d         = 1'b0;
            lose_d        = 1'b0;
            timeout_err_d = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_d       = S_CLEAR;
                    clear_board_d = 1'b1;
                end
                S_CLEAR: begin
                    state_d      = S_SPAWN;
                    spawn_left_d = 2'd2;
                    opening_d    = 1'b1;
                    // Start index is the LFSR value seen in the first scan cycle.
                    scan_idx_d   = lfsr_d[3:0];
                    scan_cnt_d   = 4'd0;
                end
                S_SPAWN: begin
                    if (cell_matrix[scan_idx_q] == 4'd0) begin
                        spawn_en_d  = 1'b1;
                        spawn_idx_d = scan_idx_q;
                        spawn_val_d = (lfsr_q[7:4] == 4'd0) ? 4'd2 : 4'd1;
                        state_d     = S_SPAWN_WR;
                    end else if (scan_cnt_q == 4'd15) begin
                        spawn_left_d = 2'd0;
                        state_d      = S_CHECK;
                    end else begin
                        scan_idx_d = scan_idx_q + 4'd1;
                        scan_cnt_d = scan_cnt_q + 4'd1;
                    end
                end
                S_SPAWN_WR: begin
                    // Board writes the tile at the end of this cycle, so the
                    // next scan or CHECK sees the updated matrix.
                    if (spawn_left_q == 2'd2) begin
                        spawn_left_d = 2'd1;
                        state_d      = S_SPAWN;
                        scan_idx_d   = lfsr_d[3:0];
                        scan_cnt_d   = 4'd0;
                    end else begin
                        spawn_left_d = 2'd0;
                        state_d      = opening_q ? S_READY : S_CHECK;
                    end
                end
                S_READY: begin
                    if (btn_edge != 4'd0) begin
                        if (btn_edge[0])      move_cmd_d = 4'b0001;
                        else if (btn_edge[1]) move_cmd_d = 4'b0010;
                        else if (btn_edge[2]) move_cmd_d = 4'b0100;
                        else                  move_cmd_d = 4'b1000;
                        state_d = S_MOVE;
                        timer_d = '0;
                    end
                end
                S_MOVE: begin
                    if (board_done) begin
                        move_cmd_d = 4'd0;
                        if (board_moved) begin
                            state_d      = S_SPAWN;
                            spawn_left_d = 2'd1;
                            opening_d    = 1'b0;
                            scan_idx_d   = lfsr_d[3:0];
                            scan_cnt_d   = 4'd0;
                        end else begin
                            state_d = S_READY;
                        end
                    end else if (timer_q == TMR_LAST) begin
                        move_cmd_d    = 4'd0;
                        timeout_err_d = 1'b1;
                        state_d       = S_READY;
                    end else begin
                        timer_d = timer_q + 1'b1;
                    end
                end
                S_CHECK: begin
                    if (any_win) begin
                        win_d   = 1'b1;
                        state_d = S_WIN;
                    end else if (!any_zero && !any_pair) begin
                        lose_d  = 1'b1;
                        state_d = S_LOSE;
                    end else begin
                        state_d = S_READY;
                    end
                end
                S_WIN, S_LOSE: state_d = state_q;
                default:       state_d = S_IDLE;
            endcase
        end

        busy_d = !((state_d == S_READY) || (state_d == S_WIN) || (state_d == S_LOSE));
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            btn_q         <= 4'd0;
            lfsr_q        <= LFSR_SEED;
            move_cmd_q    <= 4'd0;
            clear_board_q <= 1'b0;
            spawn_en_q    <= 1'b0;
            spawn_idx_q   <= 4'd0;
            spawn_val_q   <= 4'd0;
            win_q         <= 1'b0;
            lose_q        <= 1'b0;
            busy_q        <= 1'b0;
            timeout_err_q <= 1'b0;
            timer_q       <= '0;
            scan_idx_q    <= 4'd0;
            scan_cnt_q    <= 4'd0;
            spawn_left_q  <= 2'd0;
            opening_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            btn_q         <= btn_d;
            lfsr_q        <= lfsr_d;
            move_cmd_q    <= move_cmd_d;
            clear_board_q <= clear_board_d;
            spawn_en_q    <= spawn_en_d;
            spawn_idx_q   <= spawn_idx_d;
            spawn_val_q   <= spawn_val_d;
            win_q         <= win_d;
            lose_q        <= lose_d;
            busy_q        <= busy_d;
            timeout_err_q <= timeout_err_d;
            timer_q       <= timer_d;
            scan_idx_q    <= scan_idx_d;
            scan_cnt_q    <= scan_cnt_d;
            spawn_left_q  <= spawn_left_d;
            opening_q     <= opening_d;
        end
    end

    assign move_cmd    = move_cmd_q;
    assign clear_board = clear_board_q;
    assign spawn_en    = spawn_en_q;
    assign spawn_idx   = spawn_idx_q;
    assign spawn_val   = spawn_val_q;
    assign win         = win_q;
    assign lose        = lose_q;
    assign busy        = busy_q;
    assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_game_flow_controller.sv
// -----------------------------------------------------------------------------
// tb_game_flow_controller
//   Self-checking bench for game_flow_controller. A small board model applies
//   clear/spawn writes; move commands and spawn results are predicted into
//   scoreboard queues and compared by monitors when the DUT produces them.
// -----------------------------------------------------------------------------
module tb_game_flow_controller;

    localparam logic [15:0] SEED = 16'hACE1;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             btn_up = 1'b0, btn_down = 1'b0, btn_left = 1'b0, btn_right = 1'b0;
    logic             new_game = 1'b0;
    logic [3:0]       win_sel = 4'd0;
    logic [15:0][3:0] cells = '0;
    logic             board_done = 1'b0, board_moved = 1'b0;
    logic [3:0]       move_cmd;
    logic             clear_board, spawn_en;
    logic [3:0]       spawn_idx, spawn_val;
    logic             win, lose, busy, timeout_err;

    int errors = 0;
    int checks = 0;
    int spawn_count = 0;

    typedef struct packed {
        logic [3:0] idx;
        logic [3:0] val;
    } spawn_t;

    logic [3:0] move_exp_q[$];
    spawn_t     spawn_exp_q[$];

    logic             load_req = 1'b0;
    logic [15:0][3:0] load_cells = '0;
    logic [15:0]      lfsr_m;
    logic [3:0]       prev_move = 4'd0;

    always #5 clk = ~clk;

    game_flow_controller dut (
        .clk(clk), .rst(rst),
        .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
        .new_game(new_game), .win_sel(win_sel), .cell_matrix(cells),
        .board_done(board_done), .board_moved(board_moved),
        .move_cmd(move_cmd), .clear_board(clear_board), .spawn_en(spawn_en),
        .spawn_idx(spawn_idx), .spawn_val(spawn_val),
        .win(win), .lose(lose), .busy(busy), .timeout_err(timeout_err)
    );

    function automatic logic [15:0] lfsr_step(input logic [15:0] l);
        return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
    endfunction

    function automatic logic [15:0][3:0] checker_board();
        logic [15:0][3:0] b;
        for (int i = 0; i < 16; i++) b[i] = (((i / 4) + (i % 4)) % 2 == 1) ? 4'd4 : 4'd3;
        return b;
    endfunction

    // Board model: clear, spawn write, or a bench preload.
    always @(posedge clk) begin
        if (clear_board)   cells <= '0;
        else if (spawn_en) cells[spawn_idx] <= spawn_val;
        else if (load_req) cells <= load_cells;
    end

    // Reference LFSR: seeded by reset, steps every cycle.
    always @(posedge clk or posedge rst) begin
        if (rst) lfsr_m <= SEED;
        else     lfsr_m <= lfsr_step(lfsr_m);
    end

    // Scoreboard monitors.
    always @(negedge clk) begin
        spawn_t     se;
        logic [3:0] me;
        if (!rst) begin
            if (spawn_en) begin
                spawn_count++;
                if (spawn_exp_q.size() > 0) begin
                    se = spawn_exp_q.pop_front();
                    checks++;
                    if ({spawn_idx, spawn_val} !== se) begin
                        errors++;
                        $display("FAIL spawn: got idx=%0d val=%0d expected idx=%0d val=%0d",
                                 spawn_idx, spawn_val, se.idx, se.val);
                    end
                end
            end
            if (move_cmd != 4'd0 && prev_move == 4'd0) begin
                checks++;
                if (move_exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_move: got %b expected none", move_cmd);
                end else begin
                    me = move_exp_q.pop_front();
                    if (move_cmd !== me) begin
                        errors++;
                        $display("FAIL move_cmd: got %b expected %b", move_cmd, me);
                    end
                end
            end
        end
        prev_move = move_cmd;
    end

    task automatic set_btns(input logic [3:0] b);
        {btn_right, btn_left, btn_down, btn_up} = b;
    endtask

    task automatic load_board(input logic [15:0][3:0] b);
        @(negedge clk);
        load_cells = b;
        load_req   = 1'b1;
        @(negedge clk);
        load_req   = 1'b0;
    endtask

    task automatic wait_ready(input string name, input int budget);
        int n = 0;
        while (busy !== 1'b0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL %s: busy still %b after %0d cycles, expected 0", name, busy, budget);
        end
    endtask

    task automatic pulse_done(input logic moved);
        @(negedge clk);
        board_done  = 1'b1;
        board_moved = moved;
        @(negedge clk);
        board_done  = 1'b0;
        board_moved = 1'b0;
    endtask

    task automatic test_reset();
        int base;
        int nz;
        @(negedge clk);
        checks++;
        if ({move_cmd, clear_board, spawn_en, spawn_idx, spawn_val, win, lose, busy, timeout_err} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got %b expected 0",
                     {move_cmd, clear_board, spawn_en, spawn_idx, spawn_val, win, lose, busy, timeout_err});
        end
        base = spawn_count;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (clear_board !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL clear_cycle1: got clear=%b busy=%b expected 1 1", clear_board, busy);
        end
        @(negedge clk);
        checks++;
        if (clear_board !== 1'b0) begin
            errors++;
            $display("FAIL clear_pulse_width: got %b expected 0", clear_board);
        end
        wait_ready("reset_ready", 40);
        checks++;
        if (spawn_count - base !== 2) begin
            errors++;
            $display("FAIL opening_spawns: got %0d expected 2", spawn_count - base);
        end
        nz = 0;
        for (int i = 0; i < 16; i++) if (cells[i] != 4'd0) nz++;
        checks++;
        if (nz !== 2) begin
            errors++;
            $display("FAIL opening_tiles: got %0d expected 2", nz);
        end
    endtask

    task automatic test_priority();
        int base = spawn_count;
        @(negedge clk);
        set_btns(4'b0101);               // up + left together
        move_exp_q.push_back(4'b0001);
        @(negedge clk);
        checks++;
        if (move_cmd !== 4'b0001 || busy !== 1'b1) begin
            errors++;
            $display("FAIL priority: got move=%b busy=%b expected 0001 1", move_cmd, busy);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (move_cmd !== 4'b0001) begin
            errors++;
            $display("FAIL move_hold: got %b expected 0001", move_cmd);
        end
        board_done = 1'b1;
        board_moved = 1'b0;
        @(negedge clk);
        board_done = 1'b0;
        checks++;
        if (move_cmd !== 4'b0000 || busy !== 1'b0) begin
            errors++;
            $display("FAIL no_move_return: got move=%b busy=%b expected 0000 0", move_cmd, busy);
        end
        repeat (5) @(negedge clk);       // buttons still held: must not repeat
        checks++;
        if (spawn_count !== base || move_cmd !== 4'b0000) begin
            errors++;
            $display("FAIL no_move_quiet: got spawns=%0d move=%b expected %0d 0000",
                     spawn_count, move_cmd, base);
        end
        set_btns(4'b0000);
    endtask

    task automatic test_spawn_wrap();
        logic [15:0][3:0] b;
        logic [15:0]      l;
        spawn_t           e;
        bit               found = 0;
        int               edges = 0;
        for (int i = 0; i < 16; i++) b[i] = 4'd1;
        b[3] = 4'd0;
        load_board(b);
        set_btns(4'b1000);
        move_exp_q.push_back(4'b1000);
        @(negedge clk);
        set_btns(4'b0000);
        // Release board_done on the edge after which lfsr[3:0] will be 5.
        for (int i = 0; i < 200; i++) begin
            l = lfsr_step(lfsr_m);
            if (l[3:0] == 4'd5) begin
                found = 1;
                break;
            end
            @(negedge clk);
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL lfsr_align: got no start index 5 within 200 cycles expected one");
        end
        l = lfsr_m;
        for (int k = 0; k < 15; k++) l = lfsr_step(l);
        e.idx = 4'd3;
        e.val = (l[7:4] == 4'd0) ? 4'd2 : 4'd1;
        spawn_exp_q.push_back(e);
        board_done = 1'b1;
        board_moved = 1'b1;
        @(negedge clk);
        board_done = 1'b0;
        board_moved = 1'b0;
        checks++;
        if (move_cmd !== 4'b0000) begin
            errors++;
            $display("FAIL wrap_move_drop: got %b expected 0000", move_cmd);
        end
        while (!spawn_en && edges < 40) begin
            @(negedge clk);
            edges++;
        end
        checks++;
        if (edges !== 15) begin
            errors++;
            $display("FAIL wrap_latency: got %0d cycles expected 15", edges);
        end
        wait_ready("wrap_ready", 20);
        checks++;
        if (win !== 1'b0 || lose !== 1'b0 || cells[3] == 4'd0) begin
            errors++;
            $display("FAIL wrap_check: got win=%b lose=%b cell3=%0d expected 0 0 nonzero",
                     win, lose, cells[3]);
        end
    endtask

    task automatic test_win();
        logic [15:0][3:0] b;
        int base = spawn_count;
        int n = 0;
        win_sel = 4'b0100;               // target exponent 9
        b = checker_board();
        b[0]  = 4'd9;
        b[15] = 4'd0;                    // full, no pairs after spawn: win beats lose
        load_board(b);
        set_btns(4'b0001);
        move_exp_q.push_back(4'b0001);
        @(negedge clk);
        set_btns(4'b0000);
        pulse_done(1'b1);
        while (win !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (win !== 1'b1 || lose !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL win: got win=%b lose=%b busy=%b expected 1 0 0", win, lose, busy);
        end
        checks++;
        if (spawn_count - base !== 1 || cells[15] == 4'd0) begin
            errors++;
            $display("FAIL win_spawn: got %0d spawns cell15=%0d expected 1 nonzero",
                     spawn_count - base, cells[15]);
        end
        set_btns(4'b0010);
        repeat (5) @(negedge clk);
        set_btns(4'b0000);
        checks++;
        if (move_cmd !== 4'b0000 || win !== 1'b1) begin
            errors++;
            $display("FAIL win_locked: got move=%b win=%b expected 0000 1", move_cmd, win);
        end
    endtask

    task automatic test_new_game(input string name);
        @(negedge clk);
        new_game = 1'b1;
        set_btns(4'b0100);               // edge outside READY: must be dropped
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (clear_board !== 1'b1 || {win, lose, timeout_err, move_cmd, spawn_en} !== '0) begin
                errors++;
                $display("FAIL %s: got clear=%b win=%b lose=%b terr=%b move=%b spawn=%b expected 1 0 0 0 0000 0",
                         name, clear_board, win, lose, timeout_err, move_cmd, spawn_en);
            end
        end
        new_game = 1'b0;
        @(negedge clk);
        wait_ready(name, 40);
        set_btns(4'b0000);
    endtask

    task automatic test_lose();
        int base;
        int n = 0;
        win_sel = 4'b0000;
        load_board(checker_board());
        base = spawn_count;
        set_btns(4'b0100);
        move_exp_q.push_back(4'b0100);
        @(negedge clk);
        set_btns(4'b0000);
        pulse_done(1'b1);
        while (lose !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (lose !== 1'b1 || win !== 1'b0 || spawn_count !== base) begin
            errors++;
            $display("FAIL lose: got lose=%b win=%b spawns=%0d expected 1 0 %0d",
                     lose, win, spawn_count, base);
        end
    endtask

    task automatic test_timeout();
        int cnt = 0;
        set_btns(4'b0010);
        move_exp_q.push_back(4'b0010);
        @(negedge clk);
        set_btns(4'b0000);
        while (move_cmd !== 4'b0000 && cnt < 400) begin
            cnt++;
            @(negedge clk);
        end
        checks++;
        if (cnt !== 255) begin
            errors++;
            $display("FAIL timeout_len: got %0d cycles expected 255", cnt);
        end
        checks++;
        if (timeout_err !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL timeout_flag: got terr=%b busy=%b expected 1 0", timeout_err, busy);
        end
    endtask

    task automatic test_new_game_mid_move();
        set_btns(4'b0001);
        move_exp_q.push_back(4'b0001);
        @(negedge clk);
        set_btns(4'b0000);
        new_game = 1'b1;
        @(negedge clk);
        new_game = 1'b0;
        checks++;
        if (move_cmd !== 4'b0000 || clear_board !== 1'b1) begin
            errors++;
            $display("FAIL ng_mid_move: got move=%b clear=%b expected 0000 1", move_cmd, clear_board);
        end
        wait_ready("ng_mid_move_ready", 40);
    endtask

    task automatic test_async_reset();
        int base;
        set_btns(4'b1000);
        move_exp_q.push_back(4'b1000);
        @(negedge clk);
        set_btns(4'b0000);
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({move_cmd, clear_board, spawn_en, win, lose, busy, timeout_err} !== '0) begin
            errors++;
            $display("FAIL async_reset: got %b expected 0",
                     {move_cmd, clear_board, spawn_en, win, lose, busy, timeout_err});
        end
        @(negedge clk);
        base = spawn_count;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (clear_board !== 1'b1) begin
            errors++;
            $display("FAIL async_reset_restart: got clear=%b expected 1", clear_board);
        end
        wait_ready("async_reset_ready", 40);
        checks++;
        if (spawn_count - base !== 2) begin
            errors++;
            $display("FAIL async_reset_spawns: got %0d expected 2", spawn_count - base);
        end
    endtask

    initial begin
        test_reset();
        test_priority();
        test_spawn_wrap();
        test_win();
        test_new_game("ng_from_win");
        test_lose();
        test_new_game("ng_from_lose");
        test_timeout();
        test_new_game("ng_clear_timeout");
        test_new_game_mid_move();
        test_async_reset();
        repeat (3) @(negedge clk);
        checks++;
        if (move_exp_q.size() !== 0 || spawn_exp_q.size() !== 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d moves %0d spawns pending expected 0 0",
                     move_exp_q.size(), spawn_exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
